morse_sequencer: RTL and testbench

//  Parametrised Morse character transmitter. Selects a character from an internal

---
 rtl/morse_sequencer_if.sv | 14 +
 rtl/morse_sequencer.sv | 151 +++++++++++++++
 tb/tb_morse_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/morse_sequencer_if.sv
// Handshake and serial-output bundle for morse_sequencer.
// The master side drives select/control; the slave side returns busy/done/morse_out.
interface morse_sequencer_if #(parameter int SEL_W = 3);
  logic [SEL_W-1:0] sel;
  logic             start;
  logic             abort;
  logic             repeat_en;
  logic             busy;
  logic             done;
  logic             morse_out;

  modport master (output sel, start, abort, repeat_en, input busy, done, morse_out);
  modport slave  (input sel, start, abort, repeat_en, output busy, done, morse_out);
endinterface

// File: rtl/morse_sequencer.sv
// Morse character transmitter: ROM pattern serialised LSB first, then a fixed low gap.
// Optional MORSE_REPEAT_EN: retransmit the latched character from DONE while repeat_en=1.
module morse_sequencer #(
  parameter int PAT_W     = 16,
  parameter int SEL_W     = 3,
  parameter int CLK_DIV   = 2,
  parameter int GAP_UNITS = 3
) (
  input  logic               Clock,
  input  logic               reset,
  morse_sequencer_if.slave   bus
);
  localparam int LEN_W   = $clog2(PAT_W + 1);
  localparam int TICK_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_CYC = GAP_UNITS * CLK_DIV;
  localparam int GAP_W   = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  typedef struct packed {
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
  } rom_ent_t;

  function automatic rom_ent_t rom(input logic [SEL_W-1:0] s);
    rom_ent_t e;
    e = '0;
    case (32'(s))
      0: e = '{pat: PAT_W'(16'h001D), len: LEN_W'(5)};
      1: e = '{pat: PAT_W'(16'h0157), len: LEN_W'(9)};
      2: e = '{pat: PAT_W'(16'h05D7), len: LEN_W'(11)};
      3: e = '{pat: PAT_W'(16'h0057), len: LEN_W'(7)};
      4: e = '{pat: PAT_W'(16'h0001), len: LEN_W'(1)};
      5: e = '{pat: PAT_W'(16'h0175), len: LEN_W'(9)};
      6: e = '{pat: PAT_W'(16'h0177), len: LEN_W'(9)};
      7: e = '{pat: PAT_W'(16'h0055), len: LEN_W'(7)};
      default: e = '0;
    endcase
    return e;
  endfunction

  state_t           state_q, state_n;
  logic [PAT_W-1:0] shreg_q, shreg_n;
  logic [LEN_W-1:0] rem_q, rem_n;
  logic [TICK_W-1:0] tick_q, tick_n;
  logic [GAP_W-1:0] gcnt_q, gcnt_n;
  logic             busy_q, done_q, morse_q;
  rom_ent_t         ent_in;

  assign ent_in = rom(bus.sel);

`ifdef MORSE_REPEAT_EN
  logic [SEL_W-1:0] sel_q, sel_n;
  rom_ent_t         ent_rep;
  assign ent_rep = rom(sel_q);
`else
  logic unused_repeat;
  assign unused_repeat = bus.repeat_en;
`endif

  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    rem_n   = rem_q;
    tick_n  = tick_q;
    gcnt_n  = gcnt_q;
`ifdef MORSE_REPEAT_EN
    sel_n   = sel_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        shreg_n = ent_in.pat;
        rem_n   = ent_in.len;
        tick_n  = '0;
        gcnt_n  = '0;
`ifdef MORSE_REPEAT_EN
        sel_n   = bus.sel;
`endif
        state_n = (ent_in.len == '0) ? GAP : SEND;
      end
      SEND: if (bus.abort) begin
        state_n = IDLE;
      end else if (tick_q == TICK_W'(CLK_DIV - 1)) begin
        tick_n  = '0;
        shreg_n = shreg_q >> 1;
        rem_n   = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) begin
          state_n = GAP;
          gcnt_n  = '0;
        end
      end else begin
        tick_n = tick_q + 1'b1;
      end
      GAP: if (bus.abort) begin
        state_n = IDLE;
      end else if (gcnt_q == GAP_W'(GAP_CYC - 1)) begin
        gcnt_n  = '0;
        state_n = DONE;
      end else begin
        gcnt_n = gcnt_q + 1'b1;
      end
      DONE: begin
        state_n = IDLE;
`ifdef MORSE_REPEAT_EN
        // Reload from the latched select; the live sel input is not consulted here.
        if (bus.repeat_en) begin
          shreg_n = ent_rep.pat;
          rem_n   = ent_rep.len;
          tick_n  = '0;
          gcnt_n  = '0;
          state_n = (ent_rep.len == '0) ? GAP : SEND;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are flopped from next-state values so they align with the new state.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      tick_q  <= '0;
      gcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      morse_q <= 1'b0;
`ifdef MORSE_REPEAT_EN
      sel_q   <= '0;
`endif
    end else begin
      state_q <= state_n;
      shreg_q <= shreg_n;
      rem_q   <= rem_n;
      tick_q  <= tick_n;
      gcnt_q  <= gcnt_n;
      busy_q  <= (state_n == SEND) || (state_n == GAP);
      done_q  <= (state_n == DONE);
      morse_q <= (state_n == SEND) && shreg_n[0];
`ifdef MORSE_REPEAT_EN
      sel_q   <= sel_n;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.morse_out = morse_q;
endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer against a unit-level waveform model.
module tb_morse_sequencer;
  localparam int SEL_W = 3, CLK_DIV = 2, GAP_UNITS = 3;
  localparam logic [15:0] ROM_PAT [0:7] = '{16'h001D, 16'h0157, 16'h05D7, 16'h0057,
                                            16'h0001, 16'h0175, 16'h0177, 16'h0055};
  localparam int ROM_LEN [0:7] = '{5, 9, 11, 7, 1, 9, 9, 7};

  logic Clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0, n_fail = 0;
  logic [2:0] exp_q [$];

  morse_sequencer_if #(.SEL_W(SEL_W)) bus();
  morse_sequencer #(.PAT_W(16), .SEL_W(SEL_W), .CLK_DIV(CLK_DIV), .GAP_UNITS(GAP_UNITS))
    dut (.Clock(Clock), .reset(reset), .bus(bus));

  always #5 Clock = ~Clock;

  function automatic logic [2:0] obs_now();
    return {bus.busy, bus.done, bus.morse_out};
  endfunction

  // Expected {busy,done,morse_out} per cycle from the first cycle after start is taken.
  function automatic void model_char(input int s);
    logic [15:0] p;
    p = ROM_PAT[s];
    for (int u = 0; u < ROM_LEN[s]; u++)
      for (int c = 0; c < CLK_DIV; c++) exp_q.push_back({2'b10, p[u]});
    for (int c = 0; c < GAP_UNITS * CLK_DIV; c++) exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
  endfunction

  function automatic void model_idle(input int n);
    for (int c = 0; c < n; c++) exp_q.push_back(3'b000);
  endfunction

  task automatic test_reset();
    bus.start = 1'b1; bus.sel = '0; bus.abort = 1'b0; bus.repeat_en = 1'b0;
    repeat (2) @(negedge Clock);
    n_chk++;
    if (obs_now() !== 3'b000) begin n_fail++; $display("FAIL reset_hold got=%b want=000", obs_now()); end
    bus.start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      n_chk++;
      if (obs_now() !== 3'b000) begin n_fail++; $display("FAIL reset_idle cyc=%0d got=%b want=000", i, obs_now()); end
    end
  endtask

  task automatic test_basic(input int s);
    exp_q.delete(); model_char(s); model_idle(2);
    @(negedge Clock); bus.sel = SEL_W'(s); bus.start = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge Clock); bus.start = 1'b0;
      n_chk++;
      if (obs_now() !== exp_q[i]) begin n_fail++; $display("FAIL basic sel=%0d cyc=%0d got=%b want=%b", s, i + 1, obs_now(), exp_q[i]); end
    end
  endtask

  task automatic test_ignore_start();
    exp_q.delete(); model_char(2); model_idle(2);
    @(negedge Clock); bus.sel = 3'd2; bus.start = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge Clock);
      n_chk++;
      if (obs_now() !== exp_q[i]) begin n_fail++; $display("FAIL ignore_start cyc=%0d got=%b want=%b", i + 1, obs_now(), exp_q[i]); end
      bus.start = (i == 3); bus.sel = (i == 3) ? 3'd5 : 3'd2;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int s;
      s = (n < 2) ? n * 7 : int'($urandom_range(7, 0));
      exp_q.delete(); model_char(s); model_idle(1 + int'($urandom_range(2, 0)));
      @(negedge Clock); bus.sel = SEL_W'(s); bus.start = 1'b1;
      foreach (exp_q[i]) begin
        @(negedge Clock);
        n_chk++;
        if (obs_now() !== exp_q[i]) begin n_fail++; $display("FAIL random sel=%0d cyc=%0d got=%b want=%b", s, i + 1, obs_now(), exp_q[i]); end
        // start/sel noise only while busy or in the done cycle, where it must be ignored
        bus.start = (exp_q[i] != 3'b000) ? 1'($urandom) : 1'b0;
        bus.sel   = SEL_W'($urandom);
      end
    end
  endtask

  task automatic test_abort();
    int ab;
    exp_q.delete(); model_char(1);
    @(negedge Clock); bus.sel = 3'd1; bus.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock); bus.start = 1'b0;
      n_chk++;
      if (obs_now() !== exp_q[i]) begin n_fail++; $display("FAIL abort_pre cyc=%0d got=%b want=%b", i + 1, obs_now(), exp_q[i]); end
    end
    bus.abort = 1'b1; bus.start = 1'b1; bus.sel = 3'd3;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clock); bus.abort = 1'b0; bus.start = 1'b0;
      n_chk++;
      if (obs_now() !== 3'b000) begin n_fail++; $display("FAIL abort_send cyc=%0d got=%b want=000", i, obs_now()); end
    end
    // abort somewhere in the gap of E, including its final gap cycle
    ab = 2 + int'($urandom_range(5, 0));
    exp_q.delete(); model_char(4);
    @(negedge Clock); bus.sel = 3'd4; bus.start = 1'b1;
    for (int i = 0; i <= ab; i++) begin
      @(negedge Clock); bus.start = 1'b0;
      n_chk++;
      if (obs_now() !== exp_q[i]) begin n_fail++; $display("FAIL abort_gap_pre cyc=%0d got=%b want=%b", i + 1, obs_now(), exp_q[i]); end
    end
    bus.abort = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock); bus.abort = 1'b0;
      n_chk++;
      if (obs_now() !== 3'b000) begin n_fail++; $display("FAIL abort_gap at=%0d cyc=%0d got=%b want=000", ab, i, obs_now()); end
    end
    // abort in IDLE alongside start has no effect
    exp_q.delete(); model_char(7); model_idle(1);
    @(negedge Clock); bus.sel = 3'd7; bus.start = 1'b1; bus.abort = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge Clock); bus.start = 1'b0; bus.abort = 1'b0;
      n_chk++;
      if (obs_now() !== exp_q[i]) begin n_fail++; $display("FAIL abort_idle cyc=%0d got=%b want=%b", i + 1, obs_now(), exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    exp_q.delete(); model_char(2);
    @(negedge Clock); bus.sel = 3'd2; bus.start = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clock); bus.start = 1'b0;
      n_chk++;
      if (obs_now() !== exp_q[i]) begin n_fail++; $display("FAIL areset_pre cyc=%0d got=%b want=%b", i + 1, obs_now(), exp_q[i]); end
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (obs_now() !== 3'b000) begin n_fail++; $display("FAIL areset_now got=%b want=000", obs_now()); end
    @(negedge Clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      n_chk++;
      if (obs_now() !== 3'b000) begin n_fail++; $display("FAIL areset_idle cyc=%0d got=%b want=000", i, obs_now()); end
    end
  endtask

  task automatic test_repeat();
    int last;
    exp_q.delete();
`ifdef MORSE_REPEAT_EN
    for (int r = 0; r < 3; r++) model_char(3);
`else
    model_char(3);
`endif
    last = exp_q.size() - 1;
    model_idle(4);
    @(negedge Clock); bus.sel = 3'd3; bus.start = 1'b1; bus.repeat_en = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge Clock);
      bus.start = 1'b0;
      bus.sel   = SEL_W'($urandom);
      n_chk++;
      if (obs_now() !== exp_q[i]) begin n_fail++; $display("FAIL repeat cyc=%0d got=%b want=%b", i + 1, obs_now(), exp_q[i]); end
      if (i >= last) bus.repeat_en = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic(0);
    test_basic(4);
    test_ignore_start();
    test_random();
    test_abort();
    test_async_reset();
    test_basic(6);
    test_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
